// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-access stage: load/store on a req/gnt/rvalid bus, registered writeback beat
module mem_stage_lsu #(
    parameter int TIMEOUT     = 16,
    parameter bit SIGN_EXT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] memData_i,
    input  logic        readWr_i,
    input  logic        writeWr_i,
    input  logic [3:0]  rmask_i,
    input  logic [3:0]  wmask_i,
    input  logic        ld_signed_i,
    input  logic [31:0] regcData_i,
    input  logic [4:0]  regcAddr_i,
    input  logic        regcWr_i,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    input  logic        d_gnt,
    input  logic        d_rvalid,
    input  logic [31:0] d_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_addr,
    output logic        wb_we,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [1:0]  cap_off;
    logic [3:0]  cap_mask;
    logic        cap_signed, cap_store, cap_wr;
    logic [4:0]  cap_waddr;

    logic        accept, is_mem, is_store, misaligned, timed_out, sext;
    logic [1:0]  off;
    logic [3:0]  sel_mask;
    logic [7:0]  shifted;
    logic [31:0] rshift, load_data;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    assign is_store   = writeWr_i;
    assign is_mem     = readWr_i || writeWr_i;
    assign off        = memAddr_i[1:0];
    assign sel_mask   = is_store ? wmask_i : rmask_i;
    assign shifted    = {4'b0000, sel_mask} << off;
    assign misaligned = |shifted[7:4];
    assign timed_out  = ((cnt + 8'd1) == TO);

    // Bring the addressed lane down to bit 0, then extend by access size.
    assign rshift = d_rdata >> {cap_off, 3'b000};
    assign sext   = cap_signed && SIGN_EXT_EN;

    always_comb begin
        load_data = rshift;
        if (!cap_mask[1])
            load_data = {{24{sext & rshift[7]}}, rshift[7:0]};
        else if (!cap_mask[3])
            load_data = {{16{sext & rshift[15]}}, rshift[15:0]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mem && !misaligned) state_next = REQ;
            REQ: begin
                if (d_gnt)          state_next = cap_store ? IDLE : RESP;
                else if (timed_out) state_next = IDLE;
            end
            RESP: if (d_rvalid || timed_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            cap_off    <= 2'd0;
            cap_mask   <= 4'd0;
            cap_signed <= 1'b0;
            cap_store  <= 1'b0;
            cap_wr     <= 1'b0;
            cap_waddr  <= 5'd0;
            d_req      <= 1'b0;
            d_we       <= 1'b0;
            d_addr     <= 32'd0;
            d_wdata    <= 32'd0;
            d_wstrb    <= 4'd0;
            wb_valid   <= 1'b0;
            wb_data    <= 32'd0;
            wb_addr    <= 5'd0;
            wb_we      <= 1'b0;
            err        <= 1'b0;
        end else begin
            state    <= state_next;
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (!is_mem) begin
                        wb_valid <= 1'b1;
                        wb_data  <= regcData_i;
                        wb_addr  <= regcAddr_i;
                        wb_we    <= regcWr_i;
                    end else if (misaligned) begin
                        wb_valid <= 1'b1;
                        err      <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_addr  <= regcAddr_i;
                    end else begin
                        cap_off    <= off;
                        cap_mask   <= sel_mask;
                        cap_signed <= ld_signed_i;
                        cap_store  <= is_store;
                        cap_wr     <= regcWr_i;
                        cap_waddr  <= regcAddr_i;
                        cnt        <= 8'd0;
                        d_req      <= 1'b1;
                        d_we       <= is_store;
                        d_addr     <= {memAddr_i[31:2], 2'b00};
                        d_wdata    <= memData_i << {off, 3'b000};
                        d_wstrb    <= is_store ? shifted[3:0] : 4'd0;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (d_gnt) begin
                        d_req <= 1'b0;
                        if (cap_store) begin
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_addr  <= cap_waddr;
                        end
                    end else if (timed_out) begin
                        d_req    <= 1'b0;
                        err      <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_addr  <= cap_waddr;
                    end
                end
                RESP: begin
                    cnt <= cnt + 8'd1;
                    if (d_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= load_data;
                        wb_we    <= cap_wr;
                        wb_addr  <= cap_waddr;
                    end else if (timed_out) begin
                        err      <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_addr  <= cap_waddr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage directly downstream of the execute unit.
- Consumes the execute stage's ALU result, store data, memory read/write enables, byte masks and writeback fields.
- Runs load/store transactions on a req/gnt/rvalid data bus and stalls upstream while a transaction is outstanding.
- Presents a registered, one-cycle writeback beat (aligned and extended load data, or the ALU result passed through) to the writeback stage.

Parameters:
- TIMEOUT, 16: bus cycles allowed from first d_req to completion before abort; 1..255.
- SIGN_EXT_EN, 1: when 1, ld_signed_i applies sign extension; when 0, all loads zero-extend.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  execute-stage result valid
- in_ready  out  1  stage can accept; high only in IDLE
- memAddr_i  in  32  ALU result; byte address for memory ops
- memData_i  in  32  store data, right-aligned
- readWr_i  in  1  load
- writeWr_i  in  1  store (readWr_i & writeWr_i both set = illegal, handled as store)
- rmask_i  in  4  load size mask at lane 0: 0001 byte, 0011 half, 1111 word
- wmask_i  in  4  store size mask, same encoding
- ld_signed_i  in  1  sign-extend load
- regcData_i  in  32  execute-stage writeback data
- regcAddr_i  in  5  writeback address
- regcWr_i  in  1  writeback enable
- d_req  out  1  bus request
- d_we  out  1  bus write
- d_addr  out  32  word-aligned address {memAddr_i[31:2],2'b00}
- d_wdata  out  32  lane-shifted store data
- d_wstrb  out  4  lane-shifted byte strobes
- d_gnt  in  1  bus accepts request
- d_rvalid  in  1  load data valid
- d_rdata  in  32  load data
- wb_valid  out  1  one-cycle writeback beat
- wb_data  out  32  writeback data
- wb_addr  out  5  writeback address
- wb_we  out  1  writeback enable
- err  out  1  one-cycle pulse: misalignment or timeout

Behaviour:
- Reset (async): state IDLE; timeout counter 0; captured request cleared; d_req, d_we, wb_valid, wb_we, err = 0; d_addr, d_wdata, d_wstrb, wb_data, wb_addr = 0. d_req drops immediately, even mid-transaction; the in-flight op is discarded with no writeback.
- FSM states: IDLE, REQ, RESP.
- Accept: in_valid & in_ready latches all inputs. Lane offset off = memAddr_i[1:0]; shifted mask = mask << off; d_wdata = memData_i << (8*off).
- Non-memory op (readWr_i = writeWr_i = 0): stay IDLE. Next cycle wb_valid=1, wb_data=regcData_i, wb_addr/wb_we passed through. Latency 1.
- Misaligned (mask<<off overflows bit 3, e.g. half at off=3, word at off≠0): no bus activity; next cycle err=1, wb_valid=1, wb_we=0.
- Memory op: IDLE→REQ. d_req=1 with d_we/d_addr/d_wdata/d_wstrb held stable until d_gnt is sampled high. d_wstrb = shifted mask for stores, 0 for loads.
  - Store granted: →IDLE; same edge wb_valid=1, wb_we=0.
  - Load granted: →RESP with d_req=0. d_rvalid is honoured only in RESP (at least one cycle after gnt).
  - Load in RESP with d_rvalid: select bytes at off; extend to 32 bits (sign if ld_signed_i & SIGN_EXT_EN); wb_data = result; wb_we = regcWr_i; wb_valid=1; →IDLE.
- Timeout: counter cleared on entering REQ, increments each cycle in REQ/RESP. On reaching TIMEOUT without completion: →IDLE, d_req=0, err=1, wb_valid=1, wb_we=0.
- in_ready = (state==IDLE). Upstream holds its inputs while in_ready=0. Back-to-back non-memory ops sustain 1 per cycle.
- wb_valid and err are single-cycle pulses; wb_data/wb_addr hold their last value otherwise.
- d_gnt and d_rvalid asserted outside REQ/RESP respectively are ignored.

Test Plan:
- Non-memory op, regcData_i=0x1234, regcAddr_i=5, regcWr_i=1 → next cycle wb_valid=1, wb_data=0x1234, wb_addr=5, wb_we=1; d_req stays 0.
- Store byte, addr 0x103, data 0xAB, wmask 0001, d_gnt after 2 cycles → d_addr=0x100, d_wstrb=1000, d_wdata=0xAB000000 held 3 cycles; in_ready=0 throughout; wb_valid pulse with wb_we=0.
- Signed half load, addr 0x202, d_rdata=0x8001xxxx → wb_data=0xFFFF8001. Same with ld_signed_i=0 → 0x00008001.
- Word load at addr 0x201 → no d_req; err=1 and wb_valid=1, wb_we=0 next cycle.
- Load with d_gnt never asserted, TIMEOUT=16 → d_req high 16 cycles then low; err pulse; FSM back in IDLE, in_ready=1.
- Assert rst during RESP → d_req/wb_valid immediately 0, no writeback; a following op executes normally.
